// File: rtl/led_ctrl_pkg.sv
// Shared mode encodings and command FSM state type for the LED pattern controller.
package led_ctrl_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_OFF    = 2'd0;
   localparam mode_t MODE_ON     = 2'd1;
   localparam mode_t MODE_BREATH = 2'd2;
   localparam mode_t MODE_BLINK  = 2'd3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PEND = 1'b1
   } cmd_state_t;

endpackage

// File: rtl/led_ch_engine.sv
// One LED channel: mode/rate/level state, brightness stepping and the registered PWM compare.
module led_ch_engine
   import led_ctrl_pkg::*;
#(
   parameter int  PWM_MAX = 255,
   parameter int  RATE_W  = 4,
   localparam int LW      = $clog2(PWM_MAX + 1)
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              tick,
   input  logic [LW-1:0]     pwm_cnt,
   input  logic              apply,
   input  logic [1:0]        new_mode,
   input  logic [RATE_W-1:0] new_rate,
   output logic              led,
   output logic              active
);

   localparam logic [LW-1:0] LVL_MAX  = LW'(PWM_MAX);
   localparam logic [LW-1:0] LVL_TURN = LW'(PWM_MAX - 1);
   localparam logic [LW:0]   FULL     = (LW + 1)'(PWM_MAX + 1);

   mode_t             mode;
   logic [RATE_W-1:0] rate;
   logic [RATE_W-1:0] presc;
   logic [LW-1:0]     level;
   logic              dir_down;
   logic              step;
   logic [LW:0]       duty;

   assign step = tick && (presc == rate);

   always_comb begin
      duty = '0;
      case (mode)
         MODE_BREATH: duty = {1'b0, level};
         MODE_BLINK:  duty = level[LW-1] ? '0 : FULL;
         default:     duty = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode     <= MODE_OFF;
         rate     <= '0;
         presc    <= '0;
         level    <= '0;
         dir_down <= 1'b0;
         led      <= 1'b0;
         active   <= 1'b0;
      end else begin
         // A command landing on a tick cycle restarts the channel; the tick is ignored here.
         if (apply) begin
            mode     <= new_mode;
            rate     <= new_rate;
            presc    <= '0;
            level    <= '0;
            dir_down <= 1'b0;
         end else if (tick) begin
            presc <= step ? '0 : presc + RATE_W'(1);
            if (step) begin
               case (mode)
                  MODE_BREATH: begin
                     if (!dir_down) begin
                        level <= level + LW'(1);
                        if (level == LVL_TURN) dir_down <= 1'b1;
                     end else begin
                        level <= level - LW'(1);
                        if (level == LW'(1)) dir_down <= 1'b0;
                     end
                  end
                  MODE_BLINK: level <= (level == LVL_MAX) ? '0 : level + LW'(1);
                  default:    level <= '0;
               endcase
            end
         end
         led    <= (mode == MODE_ON) || ((mode != MODE_OFF) && ({1'b0, pwm_cnt} < duty));
         active <= (mode != MODE_OFF);
      end
   end

endmodule

// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED pattern controller: shared PWM frame counter and tick prescaler,
// a command FSM that defers each command to the next frame boundary, and one engine per channel.
module led_pattern_ctrl
   import led_ctrl_pkg::*;
#(
   parameter int  NUM_CH   = 4,
   parameter int  PWM_MAX  = 255,
   parameter int  TICK_DIV = 10000,
   parameter int  RATE_W   = 4,
   localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [CH_W-1:0]   cmd_ch,
   input  logic [1:0]        cmd_mode,
   input  logic [RATE_W-1:0] cmd_rate,
   output logic [NUM_CH-1:0] led,
   output logic [NUM_CH-1:0] ch_active,
   output logic              frame_sof
);

   localparam int            LW       = $clog2(PWM_MAX + 1);
   localparam int            TW       = $clog2(TICK_DIV);
   localparam logic [LW-1:0] PWM_TOP  = LW'(PWM_MAX);
   localparam logic [TW-1:0] TICK_TOP = TW'(TICK_DIV - 1);

   logic [LW-1:0]     pwm_cnt;
   logic [TW-1:0]     tick_cnt;
   logic              tick;
   logic              boundary;
   logic              apply;
   cmd_state_t        state;
   logic [CH_W-1:0]   pend_ch;
   logic [1:0]        pend_mode;
   logic [RATE_W-1:0] pend_rate;

   assign tick     = (tick_cnt == TICK_TOP);
   assign boundary = (pwm_cnt == PWM_TOP);
   assign apply    = (state == ST_PEND) && boundary;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_cnt   <= '0;
         tick_cnt  <= '0;
         frame_sof <= 1'b0;
      end else begin
         pwm_cnt   <= boundary ? '0 : pwm_cnt + LW'(1);
         tick_cnt  <= tick ? '0 : tick_cnt + TW'(1);
         frame_sof <= (pwm_cnt == '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         cmd_ready <= 1'b1;
         pend_ch   <= '0;
         pend_mode <= '0;
         pend_rate <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  pend_ch   <= cmd_ch;
                  pend_mode <= cmd_mode;
                  pend_rate <= cmd_rate;
                  cmd_ready <= 1'b0;
                  state     <= ST_PEND;
               end
            end
            ST_PEND: begin
               if (boundary) begin
                  cmd_ready <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               cmd_ready <= 1'b1;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

   // Out-of-range channel indices match no engine, so such commands simply evaporate.
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      led_ch_engine #(
         .PWM_MAX (PWM_MAX),
         .RATE_W  (RATE_W)
      ) u_eng (
         .clk      (clk),
         .rst      (rst),
         .tick     (tick),
         .pwm_cnt  (pwm_cnt),
         .apply    (apply && (int'(pend_ch) == gi)),
         .new_mode (pend_mode),
         .new_rate (pend_rate),
         .led      (led[gi]),
         .active   (ch_active[gi])
      );
   end

endmodule
